// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// off-chip data memory. A miss freezes the pipeline while a whole line moves over the memory port.
module dcache_controller #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int TAG_BITS  = 22
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int INDEX_W  = $clog2(LINES);
  localparam int OFFSET_W = $clog2(LINE_BITS / 8);
  localparam int WORDS    = LINE_BITS / 32;
  localparam int WORD_W   = $clog2(WORDS);

  typedef logic [WORDS-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_REFILL_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  line_t               data_q [LINES];

  logic                 mem_enable_q;
  logic                 mem_write_q;
  logic [31:0]          mem_addr_q;
  logic [LINE_BITS-1:0] mem_data_q;

  logic [TAG_BITS-1:0] req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [WORD_W-1:0]   req_word;
  logic                req;
  logic                hit;
  logic                victim_dirty;
  logic                store_hit;
  logic                fill;
  line_t               cur_line;
  logic [TAG_BITS-1:0] victim_tag;
  logic                unused_addr_bits;

  assign req_tag   = p1_addr_i[31 -: TAG_BITS];
  assign req_index = p1_addr_i[OFFSET_W +: INDEX_W];
  assign req_word  = p1_addr_i[2 +: WORD_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign cur_line     = data_q[req_index];
  assign victim_tag   = tag_q[req_index];
  assign req          = p1_MemRead_i | p1_MemWrite_i;
  assign hit          = valid_q[req_index] & (victim_tag == req_tag);
  assign victim_dirty = valid_q[req_index] & dirty_q[req_index];
  // A simultaneous read+write is a store; the load data path still shows the old word.
  assign store_hit    = (state_q == S_IDLE) & p1_MemWrite_i & hit;
  assign fill         = (state_q == S_FETCH) & mem_ack_i;

  assign p1_stall_o = (state_q != S_IDLE) | (req & ~hit);
  assign p1_data_o  = ((state_q == S_IDLE) & p1_MemRead_i & hit) ? cur_line[req_word] : 32'h0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (req && !hit) state_d = victim_dirty ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK:   if (mem_ack_i) state_d = S_FETCH;
      S_FETCH:       if (mem_ack_i) state_d = S_REFILL_DONE;
      S_REFILL_DONE: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Memory-port outputs are registered from the next state so they hold steady until the ack.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= (state_d == S_WRITEBACK) || (state_d == S_FETCH);
      mem_write_q  <= (state_d == S_WRITEBACK);
      case (state_d)
        S_WRITEBACK: mem_addr_q <= {victim_tag, req_index, {OFFSET_W{1'b0}}};
        S_FETCH:     mem_addr_q <= {req_tag, req_index, {OFFSET_W{1'b0}}};
        default:     mem_addr_q <= '0;
      endcase
      mem_data_q <= (state_d == S_WRITEBACK) ? LINE_BITS'(cur_line) : '0;
      if (fill) begin
        valid_q[req_index] <= 1'b1;
        dirty_q[req_index] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_index] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the cleared valid bits make stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (fill) begin
        data_q[req_index] <= line_t'(mem_data_i);
        tag_q[req_index]  <= req_tag;
      end else if (store_hit) begin
        data_q[req_index][req_word] <= p1_data_i;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: the bench plays the memory and compares
// against an architectural word-level memory view plus a line-residency model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  int checks = 0;
  int errors = 0;

  // Residency model: which line-address occupies each slot and whether it differs from memory.
  bit          m_valid [32];
  bit          m_dirty [32];
  logic [21:0] m_tag   [32];
  // Off-chip memory contents (lines written back) and the CPU-visible word values.
  logic [255:0] dram [int unsigned];
  logic [31:0]  arch [int unsigned];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input int unsigned la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = (la * 32'h9E37_79B9) ^ (k * 32'h0101_0101) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] dram_line(input int unsigned la);
    return dram.exists(la) ? dram[la] : init_line(la);
  endfunction

  function automatic logic [31:0] arch_word(input int unsigned wa);
    logic [255:0] l;
    if (arch.exists(wa)) return arch[wa];
    l = dram_line(wa >> 3);
    return l[(wa % 8) * 32 +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input int unsigned la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = arch_word(la * 8 + k);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reset wipes the cache: un-written-back stores are lost, memory is the truth again.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    arch.delete();
  endtask

  // One CPU access, with the bench answering as memory after the given latencies.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input bit rd,
                           input bit wr, input int wb_lat, input int f_lat, output int stall_cycles);
    int unsigned idx = addr[9:5];
    int unsigned la  = addr[31:5];
    int unsigned wa  = addr[31:2];
    logic [21:0] tg  = addr[31:10];
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    bit          vdirty = m_valid[idx] && m_dirty[idx];
    logic [31:0] vaddr = {m_tag[idx], idx[4:0], 5'b0};
    @(negedge clk_i);
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr; mem_ack_i = 1'b0;
    #1;
    stall_cycles = 0;
    if (!hit) begin
      check("miss_detect_stall", p1_stall_o, 1);
      check("miss_detect_data", p1_data_o, 0);
      stall_cycles = 1;
      if (vdirty) begin
        for (int k = 1; k <= wb_lat; k++) begin
          @(negedge clk_i);
          mem_ack_i = (k == wb_lat);
          #1;
          check("wb_stall", p1_stall_o, 1);
          check("wb_enable", mem_enable_o, 1);
          check("wb_write", mem_write_o, 1);
          check("wb_addr", mem_addr_o, vaddr);
          check("wb_data", mem_data_o, arch_line(vaddr >> 5));
          stall_cycles++;
        end
        dram[vaddr >> 5] = arch_line(vaddr >> 5);
      end
      for (int k = 1; k <= f_lat; k++) begin
        @(negedge clk_i);
        mem_ack_i  = (k == f_lat);
        mem_data_i = (k == f_lat) ? dram_line(la) : rand_line();
        #1;
        check("fetch_stall", p1_stall_o, 1);
        check("fetch_enable", mem_enable_o, 1);
        check("fetch_write", mem_write_o, 0);
        check("fetch_addr", mem_addr_o, {addr[31:5], 5'b0});
        if (rd) check("fetch_load_data", p1_data_o, 0);
        stall_cycles++;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0; mem_data_i = rand_line();
      #1;
      check("refill_stall", p1_stall_o, 1);
      check("refill_enable", mem_enable_o, 0);
      stall_cycles++;
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_dirty[idx] = 1'b0;
      @(negedge clk_i);
      #1;
    end
    check("hit_stall", p1_stall_o, 0);
    check("hit_data", p1_data_o, rd ? arch_word(wa) : 32'h0);
    check("hit_enable", mem_enable_o, 0);
    if (wr) begin
      arch[wa] = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    int sc;
    logic [255:0] l0;
    logic [31:0]  a;
    rst_i = 1'b0; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    model_reset();
    l0 = init_line(0);
    l0[31:0] = 32'h1111_1111;
    dram[0] = l0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst_stall", p1_stall_o, 0);
    check("rst_data", p1_data_o, 0);
    check("rst_enable", mem_enable_o, 0);
    check("rst_write", mem_write_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);

    // Cold load, memory answers after 10 fetch cycles.
    do_access(32'h0000_0000, 32'h0, 1, 0, 0, 10, sc);
    check("cold_stall_len", sc, 12);
    // Store hit, then read it back.
    do_access(32'h0000_0004, 32'hDEAD_BEEF, 0, 1, 0, 0, sc);
    check("store_hit_stall_len", sc, 0);
    do_access(32'h0000_0004, 32'h0, 1, 0, 0, 0, sc);
    check("load_back_stall_len", sc, 0);
    // Conflict on index 0 evicts the dirty line.
    do_access(32'h0000_0400, 32'h0, 1, 0, 3, 5, sc);
    check("dirty_miss_stall_len", sc, 10);
    // Store miss allocates and merges.
    do_access(32'h0000_0820, 32'hCAFE_0820, 0, 1, 0, 2, sc);
    check("store_miss_stall_len", sc, 4);
    do_access(32'h0000_0820, 32'h0, 1, 0, 0, 0, sc);
    do_access(32'h0000_0824, 32'h0, 1, 0, 0, 0, sc);
    do_access(32'h0000_0C20, 32'h0, 1, 0, 2, 2, sc);
    check("merged_evict_stall_len", sc, 6);
    // Single-cycle acks on both write-back and fetch.
    do_access(32'h0000_0C24, 32'h1234_5678, 0, 1, 0, 0, sc);
    do_access(32'h0000_0020, 32'h0, 1, 0, 1, 1, sc);
    check("fast_ack_stall_len", sc, 4);

    for (int i = 0; i < 200; i++) begin
      int op = $urandom_range(0, 2);
      a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      do_access(a, $urandom, op != 1, op != 0, $urandom_range(1, 4), $urandom_range(1, 4), sc);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk_i);
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        #1;
        check("idle_stall", p1_stall_o, 0);
        check("idle_data", p1_data_o, 0);
      end
    end

    // Reset lands mid-fetch; the ack that follows must be ignored.
    a = 32'h0000_3FE0;
    @(negedge clk_i);
    p1_addr_i = a; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    #1;
    check("rstf_detect_stall", p1_stall_o, 1);
    @(negedge clk_i);
    #1;
    check("rstf_fetch_enable", mem_enable_o, 1);
    check("rstf_fetch_addr", mem_addr_o, a);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rstf_pre_edge_enable", mem_enable_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1; p1_MemRead_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = rand_line();
    #1;
    check("rstf_enable", mem_enable_o, 0);
    check("rstf_stall", p1_stall_o, 0);
    check("rstf_addr", mem_addr_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("rstf_late_ack_enable", mem_enable_o, 0);
    check("rstf_late_ack_stall", p1_stall_o, 0);
    model_reset();
    do_access(a, 32'h0, 1, 0, 0, 3, sc);
    check("rstf_remiss_stall_len", sc, 5);
    do_access(32'h0000_0000, 32'h0, 1, 0, 0, 2, sc);
    check("rstf_invalidated_stall_len", sc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
